// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the matrix accumulator array.
package mac_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    // Internal working width for exact sums; ACC_WIDTH must stay below this.
    localparam int SUM_W         = 64;
    localparam int ACC_WIDTH_DEF = 24;

    function automatic logic signed [SUM_W-1:0] acc_max(input int acc_width);
        return (64'sd1 <<< (acc_width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SUM_W-1:0] acc_min(input int acc_width);
        return -(64'sd1 <<< (acc_width - 1));
    endfunction

    localparam logic signed [SUM_W-1:0] ACC_MAX_DEF = acc_max(ACC_WIDTH_DEF);
    localparam logic signed [SUM_W-1:0] ACC_MIN_DEF = acc_min(ACC_WIDTH_DEF);

    // Returns {ovf, sum}; sum is the clamped or wrapped value, sign-extended to SUM_W.
    function automatic logic [SUM_W:0] sat_add(
        input logic signed [SUM_W-1:0] acc,
        input logic signed [SUM_W-1:0] din,
        input int                      acc_width,
        input logic                    saturate
    );
        logic signed [SUM_W-1:0] exact;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        logic signed [SUM_W-1:0] sum;
        logic                    ovf;
        int                      sh;
        exact = acc + din;
        hi    = acc_max(acc_width);
        lo    = acc_min(acc_width);
        ovf   = (exact > hi) || (exact < lo);
        sh    = SUM_W - acc_width;
        if (!ovf) begin
            sum = exact;
        end else if (saturate) begin
            sum = (exact > hi) ? hi : lo;
        end else begin
            sum = (exact <<< sh) >>> sh;
        end
        return {ovf, sum};
    endfunction

endpackage

// File: rtl/matrix_accum_lane.sv
// One accumulator lane: adder, accumulator register and sticky overflow flag.
module matrix_accum_lane
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        i_clear,
    input  logic                        i_add,
    input  logic                        i_close,
    input  logic signed [DATA_WIDTH-1:0] i_din,
    output logic signed [ACC_WIDTH-1:0]  o_sum_next,
    output logic                        o_ovf_next
);

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;
    logic signed [SUM_W-1:0]     w_acc_ext;
    logic signed [SUM_W-1:0]     w_din_ext;
    logic [SUM_W:0]              w_res;
    logic                        w_unused_hi;

    assign w_acc_ext   = {{(SUM_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_din_ext   = {{(SUM_W-DATA_WIDTH){i_din[DATA_WIDTH-1]}}, i_din};
    assign w_res       = sat_add(w_acc_ext, w_din_ext, ACC_WIDTH, SATURATE != 0);
    assign o_sum_next  = w_res[ACC_WIDTH-1:0];
    assign o_ovf_next  = r_ovf | w_res[SUM_W];
    // Upper bits only repeat the sign of an in-range result.
    assign w_unused_hi = ^w_res[SUM_W-1:ACC_WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear || (i_add && i_close)) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_add) begin
            r_acc <= o_sum_next;
            r_ovf <= o_ovf_next;
        end
    end

endmodule

// File: rtl/matrix_accum_array.sv
// LANES-wide signed tile accumulator with valid/ready on both sides and a one-entry output register.
module matrix_accum_array
    import mac_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int SATURATE   = 1,
    parameter int MAX_BEATS  = 64,
    localparam int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*ACC_WIDTH-1:0]    out_data,
    output logic [LANES-1:0]              out_ovf,
    output logic                          out_overrun,
    output logic [CW-1:0]                 beat_count
);

    acc_state_e                    r_state;
    acc_state_e                    w_state_next;
    logic [CW-1:0]                 r_beat_count;
    logic                          r_out_valid;
    logic [LANES*ACC_WIDTH-1:0]    r_out_data;
    logic [LANES-1:0]              r_out_ovf;
    logic                          r_out_overrun;
    logic                          w_accept;
    logic                          w_at_limit;
    logic                          w_close;
    logic [LANES*ACC_WIDTH-1:0]    w_sum_next;
    logic [LANES-1:0]              w_ovf_next;

    // The output register can take a new tile whenever it is empty or being drained this cycle.
    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_at_limit  = (r_beat_count == CW'(MAX_BEATS - 1));
    assign w_close     = w_accept && (in_last || w_at_limit);

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_ovf     = r_out_ovf;
    assign out_overrun = r_out_overrun;
    assign beat_count  = r_beat_count;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        matrix_accum_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .SATURATE   (SATURATE)
        ) u_lane (
            .clock      (clock),
            .reset      (reset),
            .i_clear    (clear),
            .i_add      (w_accept),
            .i_close    (w_close),
            .i_din      (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_sum_next (w_sum_next[g*ACC_WIDTH +: ACC_WIDTH]),
            .o_ovf_next (w_ovf_next[g])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = IDLE;
        end else if (w_close) begin
            w_state_next = IDLE;
        end else if (w_accept) begin
            w_state_next = ACCUM;
        end else begin
            w_state_next = r_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_beat_count <= '0;
        end else if (clear || w_close) begin
            r_beat_count <= '0;
        end else if (w_accept) begin
            r_beat_count <= r_beat_count + CW'(1);
        end
    end

    // A closing beat refills the output even while the previous tile is popped at the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_ovf     <= '0;
            r_out_overrun <= 1'b0;
        end else if (clear) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_ovf     <= '0;
            r_out_overrun <= 1'b0;
        end else if (w_close) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_sum_next;
            r_out_ovf     <= w_ovf_next;
            r_out_overrun <= !in_last;
        end else if (r_out_valid && out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

endmodule
